// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified memory port arbiter.
//   arb_state_t : arbiter FSM encoding (IDLE / ACCESS / DONE)
//   master_t    : master identifiers (M_CPU = CPU control path, M_DMA = DMA/debug loader)
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_t;

  typedef enum logic {
    M_CPU = 1'b0,
    M_DMA = 1'b1
  } master_t;

endpackage

// File: rtl/rr_pick2.sv
// Combinational 2-way round-robin picker.
//   req       in  2  request vector, bit 0 = M_CPU, bit 1 = M_DMA
//   last      in  1  master granted most recently
//   gnt_id    out 1  selected master (meaningful only when gnt_valid)
//   gnt_valid out 1  at least one request present
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  master_t    last,
  output master_t    gnt_id,
  output logic       gnt_valid
);

  always_comb begin
    gnt_valid = |req;
    gnt_id    = M_CPU;
    if (req == 2'b11) begin
      // On contention the master that did not win last time goes first.
      gnt_id = (last == M_CPU) ? M_DMA : M_CPU;
    end else if (req[1]) begin
      gnt_id = M_DMA;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the CPU's single unified memory port between two masters
// (m0 = CPU control path, m1 = DMA/debug loader). One access at a time,
// round-robin on contention, fixed-latency memory sequencing, one-cycle ack.
//   clk, rst                 clock (rising edge), async active-high reset
//   m0_req/we/addr/wdata     CPU request, held until m0_ack
//   m0_ack, m0_stall         CPU completion pulse, CPU hold (req & ~ack)
//   m1_req/we/addr/wdata     DMA request, held until m1_ack
//   m1_ack                   DMA completion pulse
//   rdata                    read data, valid in the ack cycle (holds on writes)
//   mem_ce/we/addr/wdata     memory command, stable for LATENCY cycles
//   mem_rdata                memory read data, valid LATENCY cycles after mem_ce rises
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int LATENCY = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ack,
  output logic          m0_stall,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ack,
  output logic [DW-1:0] rdata,
  output logic          mem_ce,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int CW = $clog2(LATENCY + 1);

  if (LATENCY < 1) begin : g_latency_check
    $error("mem_port_arbiter: LATENCY must be >= 1");
  end

  arb_state_t    state, state_nxt;
  master_t       owner, last_gnt, gnt_id;
  logic          gnt_valid;
  logic          grant, finish;
  logic [CW-1:0] cnt;

  rr_pick2 u_pick (
    .req       ({m1_req, m0_req}),
    .last      (last_gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and acknowledge outputs.
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    finish    = 1'b0;
    m0_ack    = 1'b0;
    m1_ack    = 1'b0;
    case (state)
      IDLE: begin
        if (gnt_valid) begin
          grant     = 1'b1;
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt == '0) begin
          finish    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        m0_ack    = (owner == M_CPU);
        m1_ack    = (owner == M_DMA);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    m0_stall = m0_req & ~m0_ack;
  end

  // Grant bookkeeping, memory command registers and read-data capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner     <= M_CPU;
      last_gnt  <= M_DMA;
      cnt       <= '0;
      mem_ce    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata     <= '0;
    end else if (grant) begin
      owner    <= gnt_id;
      last_gnt <= gnt_id;
      mem_ce   <= 1'b1;
      cnt      <= CW'(LATENCY - 1);
      if (gnt_id == M_DMA) begin
        mem_we    <= m1_we;
        mem_addr  <= m1_addr;
        mem_wdata <= m1_wdata;
      end else begin
        mem_we    <= m0_we;
        mem_addr  <= m0_addr;
        mem_wdata <= m0_wdata;
      end
    end else if (state == ACCESS) begin
      if (finish) begin
        if (!mem_we) begin
          rdata <= mem_rdata;
        end
        mem_ce <= 1'b0;
        mem_we <= 1'b0;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: instance 0 built with LATENCY=2, instance 1 with
// LATENCY=1. A transaction-level timeline model checks every cycle; directed
// vectors and sequences cover the ordering, reset and latency corner cases.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        m0_req [2], m0_we [2], m1_req [2], m1_we [2];
  logic [31:0] m0_addr [2], m0_wdata [2], m1_addr [2], m1_wdata [2];
  logic        m0_ack [2], m0_stall [2], m1_ack [2], mem_ce [2], mem_we [2];
  logic [31:0] rdata [2], mem_addr [2], mem_wdata [2], mem_rdata [2];

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(32), .DW(32), .LATENCY(2)) u_dut_l2 (
    .clk(clk), .rst(rst),
    .m0_req(m0_req[0]), .m0_we(m0_we[0]), .m0_addr(m0_addr[0]), .m0_wdata(m0_wdata[0]),
    .m0_ack(m0_ack[0]), .m0_stall(m0_stall[0]),
    .m1_req(m1_req[0]), .m1_we(m1_we[0]), .m1_addr(m1_addr[0]), .m1_wdata(m1_wdata[0]),
    .m1_ack(m1_ack[0]), .rdata(rdata[0]),
    .mem_ce(mem_ce[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0])
  );

  mem_port_arbiter #(.AW(32), .DW(32), .LATENCY(1)) u_dut_l1 (
    .clk(clk), .rst(rst),
    .m0_req(m0_req[1]), .m0_we(m0_we[1]), .m0_addr(m0_addr[1]), .m0_wdata(m0_wdata[1]),
    .m0_ack(m0_ack[1]), .m0_stall(m0_stall[1]),
    .m1_req(m1_req[1]), .m1_we(m1_we[1]), .m1_addr(m1_addr[1]), .m1_wdata(m1_wdata[1]),
    .m1_ack(m1_ack[1]), .rdata(rdata[1]),
    .mem_ce(mem_ce[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1])
  );

  function automatic int lat(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  // Memory contents seen by reads.
  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a == 32'h10) ? 32'hDEADBEEF : {a[15:0], ~a[15:0]};
  endfunction

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory: read data is only valid in the LATENCY-th cycle of mem_ce.
  int ce_run [2] = '{0, 0};
  initial forever begin
    @(negedge clk);
    for (int d = 0; d < 2; d++) ce_run[d] = mem_ce[d] ? ce_run[d] + 1 : 0;
  end

  always_comb begin
    for (int d = 0; d < 2; d++) begin
      mem_rdata[d] = (mem_ce[d] && ce_run[d] == lat(d)) ? memfn(mem_addr[d]) : 32'h0BAD0BAD;
    end
  end

  // Reference model: each access occupies a window of edges. Granted at edge g,
  // mem_ce is high after edges g..g+L-1, ack after edge g+L, next grant at g+L+2.
  int          cyc = 0;
  bit          busy [2], own [2], last_m [2], lwe [2];
  int          gedge [2];
  logic [31:0] laddr [2], lwdata [2], exp_rd [2];

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      cyc = 0;
      for (int d = 0; d < 2; d++) begin
        busy[d] = 1'b0; last_m[d] = 1'b1; exp_rd[d] = '0;
      end
    end else begin
      cyc++;
      for (int d = 0; d < 2; d++) begin
        if (busy[d] && cyc == gedge[d] + lat(d) && !lwe[d]) exp_rd[d] = memfn(laddr[d]);
        if (busy[d] && cyc == gedge[d] + lat(d) + 1) begin
          busy[d] = 1'b0;
        end else if (!busy[d] && (m0_req[d] || m1_req[d])) begin
          own[d]    = (m0_req[d] && m1_req[d]) ? !last_m[d] : m1_req[d];
          last_m[d] = own[d];
          busy[d]   = 1'b1;
          gedge[d]  = cyc;
          lwe[d]    = own[d] ? m1_we[d]    : m0_we[d];
          laddr[d]  = own[d] ? m1_addr[d]  : m0_addr[d];
          lwdata[d] = own[d] ? m1_wdata[d] : m0_wdata[d];
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      bit ec, ea0, ea1;
      ec  = busy[d] && (cyc - gedge[d]) < lat(d);
      ea0 = busy[d] && cyc == gedge[d] + lat(d) && !own[d];
      ea1 = busy[d] && cyc == gedge[d] + lat(d) && own[d];
      chk($sformatf("d%0d mem_ce", d), mem_ce[d], ec);
      chk($sformatf("d%0d mem_we", d), mem_we[d], ec && lwe[d]);
      if (ec) begin
        chk($sformatf("d%0d mem_addr", d), mem_addr[d], laddr[d]);
        chk($sformatf("d%0d mem_wdata", d), mem_wdata[d], lwdata[d]);
      end
      chk($sformatf("d%0d m0_ack", d), m0_ack[d], ea0);
      chk($sformatf("d%0d m1_ack", d), m1_ack[d], ea1);
      chk($sformatf("d%0d rdata", d), rdata[d], exp_rd[d]);
      chk($sformatf("d%0d m0_stall", d), m0_stall[d], m0_req[d] & ~ea0);
    end
  end

  task automatic drop_all();
    for (int d = 0; d < 2; d++) begin
      m0_req[d] = 1'b0; m1_req[d] = 1'b0;
    end
  endtask

  task automatic do_reset();
    drop_all();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
  endtask

  // Counts edges (the sampling edge is the first) until master m's ack.
  task automatic wait_ack(input int d, input bit m, input int maxe,
                          output int edges, output bit other_seen);
    edges = 0;
    other_seen = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      edges++;
      if (m ? m0_ack[d] : m1_ack[d]) other_seen = 1'b1;
      if (m ? m1_ack[d] : m0_ack[d]) return;
      if (edges >= maxe) begin
        edges = -1;
        return;
      end
    end
  endtask

  typedef struct {
    bit          m;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t tbl [6];
  int   e;
  bit   oth;
  int   seq [$];
  int   exp_seq [4];
  int   nack;

  initial begin
    for (int d = 0; d < 2; d++) begin
      m0_req[d] = 0; m0_we[d] = 0; m0_addr[d] = '0; m0_wdata[d] = '0;
      m1_req[d] = 0; m1_we[d] = 0; m1_addr[d] = '0; m1_wdata[d] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("reset mem_ce", mem_ce[0], 0);
    chk("reset m0_ack", m0_ack[0], 0);
    chk("reset rdata", rdata[0], 0);
    @(negedge clk);
    #2 rst = 1'b0;

    tbl[0] = '{1'b0, 1'b0, 32'h00000010, 32'h0,        32'hDEADBEEF};
    tbl[1] = '{1'b1, 1'b1, 32'h00000040, 32'h12345678, 32'hDEADBEEF};
    tbl[2] = '{1'b1, 1'b0, 32'h00001234, 32'h0,        32'h1234EDCB};
    tbl[3] = '{1'b0, 1'b1, 32'hFFFFFFFC, 32'hA5A5A5A5, 32'h1234EDCB};
    tbl[4] = '{1'b0, 1'b0, 32'h00000003, 32'h0,        32'h0003FFFC};
    tbl[5] = '{1'b1, 1'b0, 32'h80000010, 32'h0,        32'h0010FFEF};
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #2;
      if (tbl[i].m) begin
        m1_req[0] = 1; m1_we[0] = tbl[i].we; m1_addr[0] = tbl[i].addr; m1_wdata[0] = tbl[i].wdata;
      end else begin
        m0_req[0] = 1; m0_we[0] = tbl[i].we; m0_addr[0] = tbl[i].addr; m0_wdata[0] = tbl[i].wdata;
      end
      wait_ack(0, tbl[i].m, 10, e, oth);
      m0_req[0] = 0; m1_req[0] = 0;
      chk($sformatf("vec%0d ack_edges", i), e, 3);
      chk($sformatf("vec%0d rdata", i), rdata[0], tbl[i].exp_rdata);
      chk($sformatf("vec%0d other_ack", i), oth, 0);
    end

    // Tie from reset with both masters holding: m0, m1, m0, m1.
    do_reset();
    m0_req[0] = 1; m0_we[0] = 0; m0_addr[0] = 32'h100;
    m1_req[0] = 1; m1_we[0] = 0; m1_addr[0] = 32'h200;
    exp_seq = '{0, 1, 0, 1};
    seq.delete();
    for (int c = 0; c < 60 && seq.size() < 4; c++) begin
      @(posedge clk);
      #1;
      if (m0_ack[0]) seq.push_back(0);
      if (m1_ack[0]) seq.push_back(1);
    end
    drop_all();
    for (int i = 0; i < 4; i++)
      chk($sformatf("tie order %0d", i), (i < seq.size()) ? seq[i] : -1, exp_seq[i]);

    // m0 held continuously, m1 raised once: m0, m1, m0.
    do_reset();
    m0_req[0] = 1; m0_addr[0] = 32'h104;
    m1_we[0] = 1; m1_addr[0] = 32'h208; m1_wdata[0] = 32'hCAFEF00D;
    seq.delete();
    for (int c = 0; c < 60 && seq.size() < 3; c++) begin
      @(posedge clk);
      #1;
      if (m0_ack[0]) begin
        seq.push_back(0);
        if (seq.size() == 1) m1_req[0] = 1;
      end
      if (m1_ack[0]) begin
        seq.push_back(1);
        m1_req[0] = 0;
      end
    end
    drop_all();
    exp_seq = '{0, 1, 0, 0};
    for (int i = 0; i < 3; i++)
      chk($sformatf("fair order %0d", i), (i < seq.size()) ? seq[i] : -1, exp_seq[i]);

    // Reset in the middle of an m0 write; pending m1 read served afterwards.
    do_reset();
    @(posedge clk);
    #2 m0_req[0] = 1; m0_we[0] = 1; m0_addr[0] = 32'h20; m0_wdata[0] = 32'h55;
    @(posedge clk);
    #1;
    chk("midrst ce before", mem_ce[0], 1);
    chk("midrst we before", mem_we[0], 1);
    m1_req[0] = 1; m1_we[0] = 0; m1_addr[0] = 32'h300;
    #2 rst = 1'b1;
    #1;
    chk("midrst ce after", mem_ce[0], 0);
    chk("midrst we after", mem_we[0], 0);
    chk("midrst m0_ack", m0_ack[0], 0);
    m0_req[0] = 0;
    @(negedge clk);
    #2 rst = 1'b0;
    wait_ack(0, 1'b1, 10, e, oth);
    m1_req[0] = 0;
    chk("midrst m1 edges", e, 3);
    chk("midrst m0 ack seen", oth, 0);
    chk("midrst m1 rdata", rdata[0], 32'h0300FCFF);

    // LATENCY=1 instance: ack after 2 edges; dropped request still acked once.
    @(posedge clk);
    #2 m0_req[1] = 1; m0_we[1] = 0; m0_addr[1] = 32'h10;
    wait_ack(1, 1'b0, 10, e, oth);
    m0_req[1] = 0;
    chk("l1 ack edges", e, 2);
    chk("l1 rdata", rdata[1], 32'hDEADBEEF);
    @(posedge clk);
    #2 m0_req[1] = 1; m0_addr[1] = 32'h44;
    @(posedge clk);
    #2 m0_req[1] = 0;
    nack = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (m0_ack[1]) nack++;
    end
    chk("l1 drop ack count", nack, 1);
    chk("l1 drop rdata", rdata[1], 32'h0044FFBB);

    // Random traffic on both instances.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #2;
      if (c % 700 == 699) begin
        do_reset();
      end else begin
        for (int d = 0; d < 2; d++) begin
          if (m0_req[d] && m0_ack[d]) m0_req[d] = 0;
          else if (m0_req[d]) begin
            if ($urandom_range(0, 15) == 0) begin
              m0_addr[d] = $urandom; m0_wdata[d] = $urandom; m0_we[d] = $urandom_range(0, 1);
            end
            if ($urandom_range(0, 31) == 0) m0_req[d] = 0;
          end else if ($urandom_range(0, 2) == 0) begin
            m0_req[d] = 1; m0_we[d] = $urandom_range(0, 1); m0_wdata[d] = $urandom;
            m0_addr[d] = ($urandom_range(0, 3) == 0) ? 32'h10 : $urandom;
          end
          if (m1_req[d] && m1_ack[d]) m1_req[d] = 0;
          else if (m1_req[d]) begin
            if ($urandom_range(0, 15) == 0) begin
              m1_addr[d] = $urandom; m1_wdata[d] = $urandom; m1_we[d] = $urandom_range(0, 1);
            end
            if ($urandom_range(0, 31) == 0) m1_req[d] = 0;
          end else if ($urandom_range(0, 2) == 0) begin
            m1_req[d] = 1; m1_we[d] = $urandom_range(0, 1); m1_wdata[d] = $urandom;
            m1_addr[d] = ($urandom_range(0, 3) == 0) ? 32'h10 : $urandom;
          end
        end
      end
    end
    drop_all();
    repeat (6) @(posedge clk);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
